// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: holds one instruction for MEM, resolves branches, drives PC redirect and forwarding tap.
// Optional macro BRANCH_BNE_EN adds ex_branch_ne so BNE resolves alongside BEQ.
module ex_mem_pipe_reg #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ex_valid,
   output logic                  ex_ready,
   input  logic [XLEN-1:0]       ex_alu_result,
   input  logic                  ex_alu_zero,
   input  logic [XLEN-1:0]       ex_rs2_data,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_reg_write,
   input  logic                  ex_mem_read,
   input  logic                  ex_mem_write,
   input  logic                  ex_mem_to_reg,
   input  logic                  ex_branch,
`ifdef BRANCH_BNE_EN
   input  logic                  ex_branch_ne,
`endif
   input  logic [XLEN-1:0]       ex_pc,
   input  logic [XLEN-1:0]       ex_imm,
   input  logic                  flush,
   output logic                  mem_valid,
   input  logic                  mem_ready,
   output logic [XLEN-1:0]       mem_alu_result,
   output logic [XLEN-1:0]       mem_rs2_data,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic                  mem_reg_write,
   output logic                  mem_mem_read,
   output logic                  mem_mem_write,
   output logic                  mem_mem_to_reg,
   output logic                  redirect_valid,
   output logic [XLEN-1:0]       redirect_pc,
   output logic                  fwd_valid,
   output logic [REG_ADDR_W-1:0] fwd_rd,
   output logic [XLEN-1:0]       fwd_data
);

   logic accept;
   logic taken;

   // Handshake and branch resolution; taken only matters when accepted
   always_comb begin
      ex_ready = !mem_valid | mem_ready;
      accept   = ex_valid & ex_ready & !flush;
`ifdef BRANCH_BNE_EN
      taken    = ex_branch & (ex_alu_zero ^ ex_branch_ne);
`else
      taken    = ex_branch & ex_alu_zero;
`endif
   end

   // Occupancy and redirect pulse; flush suppresses accept and drops the held entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_valid      <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         redirect_valid <= accept & taken;
         if (accept & taken)
            redirect_pc <= XLEN'(ex_pc + ex_imm);
         if (flush)
            mem_valid <= 1'b0;
         else if (accept)
            mem_valid <= 1'b1;
         else if (mem_ready)
            mem_valid <= 1'b0;
      end
   end

   // Payload only moves on accept, so a stalled entry stays put
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_alu_result <= '0;
         mem_rs2_data   <= '0;
         mem_rd         <= '0;
         mem_reg_write  <= 1'b0;
         mem_mem_read   <= 1'b0;
         mem_mem_write  <= 1'b0;
         mem_mem_to_reg <= 1'b0;
      end else if (accept) begin
         mem_alu_result <= ex_alu_result;
         mem_rs2_data   <= ex_rs2_data;
         mem_rd         <= ex_rd;
         mem_reg_write  <= ex_reg_write;
         mem_mem_read   <= ex_mem_read;
         mem_mem_write  <= ex_mem_write;
         mem_mem_to_reg <= ex_mem_to_reg;
      end
   end

   // Loads have no data yet at this stage, and x0 is never a real destination
   assign fwd_valid = mem_valid & mem_reg_write & !mem_mem_read & (mem_rd != '0);
   assign fwd_rd    = mem_rd;
   assign fwd_data  = mem_alu_result;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Scoreboard bench for ex_mem_pipe_reg: driver queues expected entries, negedge monitor checks outputs.
module tb_ex_mem_pipe_reg;
   localparam int unsigned XLEN = 32;
   localparam int unsigned RW   = 5;

   typedef struct {
      logic [XLEN-1:0] alu, rs2, pc, imm;
      logic [RW-1:0]   rd;
      logic            zero, rw, mr, mw, m2r, br, bne;
   } ent_t;

   logic            clk, rst_n;
   logic            ex_valid, ex_ready, ex_alu_zero;
   logic [XLEN-1:0] ex_alu_result, ex_rs2_data, ex_pc, ex_imm;
   logic [RW-1:0]   ex_rd;
   logic            ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_branch_ne;
   logic            flush, mem_valid, mem_ready;
   logic [XLEN-1:0] mem_alu_result, mem_rs2_data, redirect_pc, fwd_data;
   logic [RW-1:0]   mem_rd, fwd_rd;
   logic            mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
   logic            redirect_valid, fwd_valid;

   int tests = 0;
   int errors = 0;

   ent_t            exp_q[$];
   bit              mv_exp = 0;
   bit              rv_exp = 0;
   logic [XLEN-1:0] rpc_exp = '0;
   bit              acc_now = 0;
   bit              taken_now = 0;
   logic [XLEN-1:0] tgt_now = '0;

   ex_mem_pipe_reg #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_alu_result(ex_alu_result), .ex_alu_zero(ex_alu_zero), .ex_rs2_data(ex_rs2_data),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
`ifdef BRANCH_BNE_EN
      .ex_branch_ne(ex_branch_ne),
`endif
      .ex_pc(ex_pc), .ex_imm(ex_imm), .flush(flush), .mem_valid(mem_valid),
      .mem_ready(mem_ready), .mem_alu_result(mem_alu_result), .mem_rs2_data(mem_rs2_data),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
      .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic ent_t zero_ent();
      ent_t e;
      e = '{default: '0};
      return e;
   endfunction

   function automatic ent_t rnd_ent();
      ent_t e;
      e.alu  = $urandom;
      e.rs2  = $urandom;
      e.pc   = $urandom;
      e.imm  = $urandom;
      e.rd   = RW'($urandom_range(0, 31));
      e.zero = 1'($urandom);
      e.rw   = 1'($urandom);
      e.mr   = ($urandom_range(0, 3) == 0);
      e.mw   = 1'($urandom);
      e.m2r  = 1'($urandom);
      e.br   = ($urandom_range(0, 2) == 0);
      e.bne  = 1'($urandom);
      return e;
   endfunction

   // Apply one cycle of stimulus and queue the expected entry if it will be taken in
   task automatic drive(input ent_t e, input bit v, input bit r, input bit f);
      ex_valid = v; mem_ready = r; flush = f;
      ex_alu_result = e.alu; ex_rs2_data = e.rs2; ex_pc = e.pc; ex_imm = e.imm;
      ex_rd = e.rd; ex_alu_zero = e.zero; ex_reg_write = e.rw; ex_mem_read = e.mr;
      ex_mem_write = e.mw; ex_mem_to_reg = e.m2r; ex_branch = e.br; ex_branch_ne = e.bne;
      acc_now = rst_n && v && (!mv_exp || r) && !f;
`ifdef BRANCH_BNE_EN
      taken_now = e.br && (e.zero != e.bne);
`else
      taken_now = e.br && e.zero;
`endif
      tgt_now = e.pc + e.imm;
      if (acc_now) exp_q.push_back(e);
   endtask

   task automatic step(input ent_t e, input bit v, input bit r, input bit f);
      @(posedge clk);
      #1;
      drive(e, v, r, f);
   endtask

   task automatic reset_midcycle();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_mem_valid", 64'(mem_valid), 64'd0);
      chk("rst_redirect_valid", 64'(redirect_valid), 64'd0);
      chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
      chk("rst_ex_ready", 64'(ex_ready), 64'd1);
      chk("rst_mem_alu_result", 64'(mem_alu_result), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: compare against the held model entry, then advance the model across the next edge
   always @(negedge clk) begin
      ent_t h;
      bit   fw;
      if (!rst_n) begin
         chk("r_mem_valid", 64'(mem_valid), 64'd0);
         chk("r_redirect_valid", 64'(redirect_valid), 64'd0);
         chk("r_redirect_pc", 64'(redirect_pc), 64'd0);
         chk("r_fwd_valid", 64'(fwd_valid), 64'd0);
         chk("r_mem_rd", 64'(mem_rd), 64'd0);
         chk("r_ex_ready", 64'(ex_ready), 64'd1);
         exp_q.delete();
         mv_exp = 0; rv_exp = 0; rpc_exp = '0; acc_now = 0;
      end else begin
         chk("ex_ready", 64'(ex_ready), 64'(!mv_exp || mem_ready));
         chk("mem_valid", 64'(mem_valid), 64'(mv_exp));
         chk("redirect_valid", 64'(redirect_valid), 64'(rv_exp));
         chk("redirect_pc", 64'(redirect_pc), 64'(rpc_exp));
         fw = 0;
         if (mv_exp && exp_q.size() > 0) begin
            h  = exp_q[0];
            fw = h.rw && !h.mr && (h.rd != 0);
            chk("mem_alu_result", 64'(mem_alu_result), 64'(h.alu));
            chk("mem_rs2_data", 64'(mem_rs2_data), 64'(h.rs2));
            chk("mem_rd", 64'(mem_rd), 64'(h.rd));
            chk("mem_ctrl", 64'({mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg}),
                64'({h.rw, h.mr, h.mw, h.m2r}));
            if (fw) begin
               chk("fwd_rd", 64'(fwd_rd), 64'(h.rd));
               chk("fwd_data", 64'(fwd_data), 64'(h.alu));
            end
         end
         chk("fwd_valid", 64'(fwd_valid), 64'(fw));
         if (flush) begin
            if (mv_exp && exp_q.size() > 0) void'(exp_q.pop_front());
            mv_exp = 0; rv_exp = 0;
         end else if (acc_now) begin
            if (mv_exp && exp_q.size() > 0) void'(exp_q.pop_front());
            mv_exp = 1; rv_exp = taken_now;
            if (taken_now) rpc_exp = tgt_now;
         end else begin
            if (mv_exp && mem_ready) begin
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               mv_exp = 0;
            end
            rv_exp = 0;
         end
      end
   end

   initial begin
      ent_t e;
      rst_n = 1'b1;
      drive(rnd_ent(), 1'b1, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("init_mem_valid", 64'(mem_valid), 64'd0);
      chk("init_ex_ready", 64'(ex_ready), 64'd1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // First accept right after reset release; result 5 to rd 3
      e = zero_ent(); e.alu = 32'h5; e.rd = 5'd3; e.rw = 1'b1;
      drive(e, 1'b1, 1'b1, 1'b0);
      step(rnd_ent(), 1'b0, 1'b0, 1'b0);
      chk("tp_fwd_valid", 64'(fwd_valid), 64'd1);
      chk("tp_fwd_rd", 64'(fwd_rd), 64'd3);
      chk("tp_fwd_data", 64'(fwd_data), 64'd5);
      step(rnd_ent(), 1'b0, 1'b1, 1'b0);

      // BEQ taken with backwards wrap, then not taken
      e = zero_ent(); e.br = 1'b1; e.zero = 1'b1; e.pc = 32'h100; e.imm = 32'hFFFF_FFF0;
      step(e, 1'b1, 1'b1, 1'b0);
      step(rnd_ent(), 1'b0, 1'b0, 1'b0);
      chk("beq_redirect_valid", 64'(redirect_valid), 64'd1);
      chk("beq_redirect_pc", 64'(redirect_pc), 64'h0F0);
      step(rnd_ent(), 1'b0, 1'b1, 1'b0);
      chk("beq_pulse_end", 64'(redirect_valid), 64'd0);
      chk("beq_pc_hold", 64'(redirect_pc), 64'h0F0);
      e.zero = 1'b0;
      step(e, 1'b1, 1'b1, 1'b0);
      step(rnd_ent(), 1'b0, 1'b1, 1'b0);
      chk("beq_nt_redirect", 64'(redirect_valid), 64'd0);

      // Three-cycle stall on rd 7, then back-to-back replace with rd 9
      e = zero_ent(); e.rd = 5'd7; e.rw = 1'b1; e.alu = 32'hCAFE;
      step(e, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(rnd_ent(), 1'b1, 1'b0, 1'b0);
         chk("stall_ex_ready", 64'(ex_ready), 64'd0);
         chk("stall_mem_rd", 64'(mem_rd), 64'd7);
      end
      e = zero_ent(); e.rd = 5'd9; e.rw = 1'b1;
      step(e, 1'b1, 1'b1, 1'b0);
      step(rnd_ent(), 1'b0, 1'b0, 1'b0);
      chk("replace_mem_valid", 64'(mem_valid), 64'd1);
      chk("replace_mem_rd", 64'(mem_rd), 64'd9);

      // Flush against an incoming taken branch
      e = zero_ent(); e.br = 1'b1; e.zero = 1'b1; e.pc = 32'h200; e.imm = 32'h40;
      step(e, 1'b1, 1'b1, 1'b1);
      step(rnd_ent(), 1'b0, 1'b0, 1'b0);
      chk("flush_mem_valid", 64'(mem_valid), 64'd0);
      chk("flush_redirect_valid", 64'(redirect_valid), 64'd0);

      // Loads and x0 never forward
      e = zero_ent(); e.rd = 5'd4; e.rw = 1'b1; e.mr = 1'b1;
      step(e, 1'b1, 1'b1, 1'b0);
      step(rnd_ent(), 1'b0, 1'b0, 1'b0);
      chk("load_fwd_valid", 64'(fwd_valid), 64'd0);
      e = zero_ent(); e.rd = 5'd0; e.rw = 1'b1;
      step(e, 1'b1, 1'b1, 1'b0);
      step(rnd_ent(), 1'b0, 1'b1, 1'b0);
      chk("x0_fwd_valid", 64'(fwd_valid), 64'd0);

`ifdef BRANCH_BNE_EN
      e = zero_ent(); e.br = 1'b1; e.bne = 1'b1; e.zero = 1'b0; e.pc = 32'hFFFF_FFFC; e.imm = 32'h8;
      step(e, 1'b1, 1'b1, 1'b0);
      step(rnd_ent(), 1'b0, 1'b1, 1'b0);
      chk("bne_redirect_valid", 64'(redirect_valid), 64'd1);
      chk("bne_redirect_pc", 64'(redirect_pc), 64'h4);
`endif

      // Randomized traffic with an asynchronous reset in the middle
      for (int i = 0; i < 600; i++) begin
         if (i == 300) begin
            reset_midcycle();
            drive(rnd_ent(), 1'b1, 1'b1, 1'b0);
         end else begin
            step(rnd_ent(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 11) == 0));
         end
      end
      step(rnd_ent(), 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule
